// File: rtl/nn_layer_sequencer_pkg.sv
// nn_seq_pkg: shared state encoding and default sizing for the layer sequencer
// Provides state_t, default layer sizes/latency/timeout, and the is_wait helper.
package nn_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, FEED1, WAIT1, FEED2, WAIT2, FEED3, WAIT3, ARGMAX, WAITA, DONE, ERROR
  } state_t;
  localparam int L1_DEF      = 784;
  localparam int L2_DEF      = 128;
  localparam int L3_DEF      = 32;
  localparam int RD_LAT_DEF  = 1;
  localparam int TIMEOUT_DEF = 1024;
  localparam int ADDR_W_DEF  = 32;
  function automatic logic is_wait(state_t s);
    return s inside {WAIT1, WAIT2, WAIT3, WAITA};
  endfunction
endpackage

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: control/handshake bundle between sequencer and layer datapath
// master: the sequencer (takes start/abort/done inputs, drives addresses, runs, status)
// slave: the surrounding top level / layers (drives start/abort/done, observes the rest)
interface nn_layer_sequencer_if import nn_seq_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic              start, abort, l1_done, l2_done, l3_done, argmax_done;
  logic [ADDR_W-1:0] rd_addr, run_addr;
  logic              l1_run, l2_run, l3_run, argmax_start, busy, done, timeout_err;
  modport master (
    input  start, abort, l1_done, l2_done, l3_done, argmax_done,
    output rd_addr, run_addr, l1_run, l2_run, l3_run, argmax_start, busy, done, timeout_err
  );
  modport slave (
    output start, abort, l1_done, l2_done, l3_done, argmax_done,
    input  rd_addr, run_addr, l1_run, l2_run, l3_run, argmax_start, busy, done, timeout_err
  );
endinterface

// File: rtl/nn_layer_sequencer_feed_gen.sv
// feed_gen: source address counter plus a lat-deep (run, run_addr) delay pipe
// Ports: clk, rst (also used as abort clear), go (FEED active), len (beats),
// lat (0-3 source latency), rd_addr, run, run_addr, last (final run beat).
module feed_gen #(parameter int ADDR_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] len,
  input  logic [1:0]        lat,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] run_addr,
  output logic              run,
  output logic              last
);
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] pa [3];
  logic [2:0]        pv;
  logic              rd_v;
  assign rd_v     = go && cnt < len;
  assign rd_addr  = rd_v ? cnt : '0;
  assign run      = go && (lat == 2'd0 ? rd_v : pv[lat - 2'd1]);
  assign run_addr = !run ? '0 : lat == 2'd0 ? rd_addr : pa[lat - 2'd1];
  assign last     = run && run_addr == len - ADDR_W'(1);
  // pipe is flushed whenever no FEED is active so no beat leaks between layers
  always_ff @(posedge clk) begin
    if (rst || !go) begin
      cnt <= '0;
      pv  <= '0;
    end else begin
      cnt <= rd_v ? cnt + ADDR_W'(1) : cnt;
      pv  <= {pv[1:0], rd_v};
    end
    pa <= '{rd_addr, pa[0], pa[1]};
  end
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: sequences three layer feeds, argmax and timeouts for one inference
// Ports: clk, rst (sync, active high), bus (master modport of nn_layer_sequencer_if):
// start/abort/lN_done/argmax_done in; rd_addr, run_addr, lN_run, argmax_start,
// busy, done, timeout_err out.
module nn_layer_sequencer import nn_seq_pkg::*; #(
  parameter int L1_INPUTS = L1_DEF,
  parameter int L2_INPUTS = L2_DEF,
  parameter int L3_INPUTS = L3_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  nn_layer_sequencer_if.master bus
);
  state_t            state, next;
  logic [31:0]       tcnt;
  logic              go, run, last, timed_out;
  logic [ADDR_W-1:0] len, rd_addr, run_addr;
  logic [1:0]        lat;
  assign go        = state inside {FEED1, FEED2, FEED3};
  assign len       = state == FEED1 ? ADDR_W'(L1_INPUTS) : state == FEED2 ? ADDR_W'(L2_INPUTS) : ADDR_W'(L3_INPUTS);
  assign lat       = state == FEED1 ? 2'(RD_LAT) : 2'd0;
  assign timed_out = tcnt >= 32'(TIMEOUT);
  feed_gen #(.ADDR_W(ADDR_W)) u_feed (
    .clk(clk), .rst(rst || bus.abort), .go(go), .len(len), .lat(lat),
    .rd_addr(rd_addr), .run_addr(run_addr), .run(run), .last(last)
  );
  // wait counter only runs while staying in the same WAIT state, so it is zero on entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= next;
      tcnt  <= is_wait(state) && next == state ? tcnt + 32'd1 : '0;
    end
  end
  // done inputs are only looked at inside their own WAIT state
  always_comb begin
    next = state;
    unique case (state)
      IDLE, ERROR: next = bus.start ? FEED1 : state;
      DONE:        next = bus.start ? FEED1 : IDLE;
      FEED1:       next = last ? WAIT1 : FEED1;
      FEED2:       next = last ? WAIT2 : FEED2;
      FEED3:       next = last ? WAIT3 : FEED3;
      WAIT1:       next = bus.l1_done ? FEED2 : timed_out ? ERROR : WAIT1;
      WAIT2:       next = bus.l2_done ? FEED3 : timed_out ? ERROR : WAIT2;
      WAIT3:       next = bus.l3_done ? ARGMAX : timed_out ? ERROR : WAIT3;
      ARGMAX:      next = WAITA;
      WAITA:       next = bus.argmax_done ? DONE : timed_out ? ERROR : WAITA;
      default:     next = IDLE;
    endcase
    if (bus.abort) next = IDLE;
  end
  assign bus.rd_addr      = rd_addr;
  assign bus.run_addr     = run_addr;
  assign bus.l1_run       = run && state == FEED1;
  assign bus.l2_run       = run && state == FEED2;
  assign bus.l3_run       = run && state == FEED3;
  assign bus.argmax_start = state == ARGMAX;
  assign bus.busy         = !(state inside {IDLE, DONE, ERROR});
  assign bus.done         = state == DONE;
  assign bus.timeout_err  = state == ERROR;
endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Sequences one MNIST inference through the three fully-connected `nn_layer` instances and the argmax stage. It generates the shared input address stream and each layer's `run` window, and waits for each layer's completion. It also guards every wait with a timeout and reports completion or error to the top level. It sits between the top-level `start`/`done` pins and the layer datapath, replacing ad-hoc address/run generation with a single, verifiable state machine.

## Interface
- `L1_INPUTS`, default 784, input beats for layer 1 (image pixels)
- `L2_INPUTS`, default 128, input beats for layer 2
- `L3_INPUTS`, default 32, input beats for layer 3
- `RD_LAT`, default 1, read latency (cycles, 0–3) of the layer-1 source (`image_rom`); layers 2/3 sources are combinational (latency 0)
- `TIMEOUT`, default 1024, max cycles spent in any WAIT state before error
- `ADDR_W`, default 32, address width
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request one inference; sampled only in IDLE/DONE/ERROR
- `abort`  in  1  synchronous abort; returns to IDLE next cycle
- `l1_done`, `l2_done`, `l3_done`  in  1 each  layer completion (pulse or level)
- `argmax_done`  in  1  argmax finished
- `rd_addr`  out  ADDR_W  address to the active layer's source (ROM / bus mux select)
- `run_addr`  out  ADDR_W  beat index aligned with `lN_run` (layer weight index)
- `l1_run`, `l2_run`, `l3_run`  out  1 each  input-valid for the respective layer
- `argmax_start`  out  1  one-cycle pulse
- `busy`  out  1  high in any state except IDLE, DONE, ERROR
- `done`  out  1  one-cycle pulse on success
- `timeout_err`  out  1  level, high in ERROR

## Operation
- States: IDLE, FEED1, WAIT1, FEED2, WAIT2, FEED3, WAIT3, ARGMAX, WAITA, DONE, ERROR.
- IDLE/DONE/ERROR + `start` -> FEED1. DONE lasts one cycle, then goes to IDLE. ERROR holds until `start` or `rst`.
- FEEDn, rd side: `rd_addr` counts 0..Nn-1, one per cycle.
- FEEDn, run side: `lN_run` and `run_addr` are the rd stream delayed by the source latency (RD_LAT for n=1, 0 for n=2/3).
- FEEDn exits after the last run beat (run_addr = Nn-1) and enters WAITn.
- `rd_addr` and `run_addr` return to 0 outside FEED. All `run` outputs are 0 outside their own FEED state, and at most one is high in any cycle.
- WAITn: timeout counter clears on entry. `lN_done` -> FEED(n+1), or ARGMAX after WAIT3. Counter reaching TIMEOUT without done -> ERROR.
- A `done` input asserted outside its WAIT state is ignored; a level left high from a prior run must not skip a WAIT.
- ARGMAX: `argmax_start` pulses for one cycle, then WAITA (same timeout rule) until `argmax_done` -> DONE.
- `abort`: from any state -> IDLE next cycle, all outputs 0, counters cleared. `abort` has priority over `start` and over done inputs.
- `start` while `busy` is ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` sampled at cycle 0 -> FEED1 at cycle 1 with `rd_addr`=0. First `l1_run` at cycle 1+RD_LAT with `run_addr`=0.
- Last `l1_run` is at cycle L1_INPUTS+RD_LAT, and WAIT1 starts the following cycle.
- `lN_done` sampled in cycle t -> `rd_addr`=0 and (if lat 0) `l(n+1)_run` at t+1.
- `argmax_done` at t -> `done` pulse at t+1, `busy` low at t+1.
- Timeout: entry to WAIT at cycle e, no done -> `timeout_err` high at e+TIMEOUT+1.
- No bubbles inside a FEED: run beats are contiguous.

## Structure
- Package `nn_seq_pkg`: state enum, default layer sizes, `RD_LAT`/`TIMEOUT` defaults, shared with `mnist_top` and the bench.
- Sub-module `feed_gen`: address counter plus an RD_LAT-deep (run, run_addr) delay pipe. It has inputs `go`, `len`, `lat` and output `last`, and is instantiated once and shared across layers (`len`/`lat` muxed by state).
- Top FSM, timeout counter and output decode live in `nn_layer_sequencer`.

## Test plan
- Nominal run (defaults): done responders fire 5 cycles after each run window. Expect exactly 784/128/32 `run` beats with `run_addr` 0..N-1, `l1_run` lagging `rd_addr` by 1, one `argmax_start`, and one `done`.
- RD_LAT=0 and 3: `l1_run`/`run_addr` lag is exactly 0 and 3; beat count stays 784; FEED1 length is 784+lat.
- `l2_done` never arrives, TIMEOUT=16: `timeout_err` rises 17 cycles after WAIT2 entry and `busy` drops. A later `start` restarts cleanly from `rd_addr`=0.
- `abort` at beat 400 of FEED1: next cycle IDLE, all outputs 0. A new `start` then yields a full 784-beat window with no stale beats.
- `l1_done` held high continuously, plus `start` pulsed while busy: WAIT1 is not skipped prematurely (FEED1 runs all beats first), and the second `start` has no effect.
- Reset asserted in WAIT3: outputs 0 next cycle; no `done` or `argmax_start` is emitted afterwards.
